nibble_add_seq: RTL and testbench
=================================

// Module: nibble_add_seq
// PURPOSE
//  Multi-cycle sequencer that computes WIDTH-bit additions through one shared 4-bit ripple-carry slice.
//  - One nibble per clock, LSB first; carry is registered between nibbles.
//  - Operands and results move over valid/ready handshakes.
//  - Sits between an operand producer and a result consumer; trades latency for adder area.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand request valid
//  in_ready   out  1      sequencer can accept operands
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B
//  c_in       in   1      carry-in for nibble 0
//  op_sub     in   1      1 = A-B (only when NIBBLE_ADD_SUB_EN is defined)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  c_out      out  1      carry out of the MSB nibble
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset values: in_ready=0 while rst is high and 1 in the first cycle after release; out_valid=0; sum=0; c_out=0; busy=0.
//    Internal state resets to IDLE, nibble counter to 0, carry register to 0.
//  - FSM states:
//    IDLE: in_ready=1. On in_valid&in_ready: latch op_a, op_b, c_in into the carry register; counter=0; go to RUN.
//    RUN: each cycle the slice adds nibble[cnt] of A and B plus the carry register.
//      The nibble result goes to sum[4*cnt+:4]; the slice carry goes to the carry register; cnt++.
//      When cnt == WIDTH/4-1: go to DONE, c_out = slice carry.
//    DONE: out_valid=1; sum and c_out are stable. On out_valid&out_ready go to IDLE; out_valid falls the next cycle.
//  - Latency: out_valid rises exactly WIDTH/4 rising edges after the accept edge (4 for WIDTH=16).
//    Throughput: at most one operation per WIDTH/4+2 cycles.
//  - No overlap: in_ready=0 in RUN and DONE. in_valid there is ignored and no operands are captured.
//  - sum/c_out are held unchanged in IDLE after a handshake until the next RUN overwrites them.
//  - Arithmetic is modulo 2^WIDTH. c_out is the unsigned carry. No overflow flag.
//  - Reset mid-RUN or mid-DONE aborts immediately: all outputs return to reset values, with no partial result and no out_valid pulse.
//  - out_ready held low in DONE: stay in DONE indefinitely with outputs frozen.
// CONFIGURATION
//  - NIBBLE_ADD_SUB_EN defined:
//    op_sub is latched at accept. When 1, B nibbles are inverted before the slice and the carry register loads 1 (c_in ignored).
//    Result is A-B mod 2^WIDTH; c_out=1 means no borrow.
//  - Not defined: op_sub port absent; add only.
// STRUCTURE
//  - Shared package nibble_add_pkg: NIBBLE_W=4 constant; FSM state typedef {IDLE, RUN, DONE}.
//  - One sub-module, nibble_adder: combinational 4-bit ripple-carry slice (a, b, ci -> s, co) built from 1-bit full-adder cells.
//  - The FSM, counter, operand/result registers and handshake live in nibble_add_seq.
// TESTING
//  1. WIDTH=16: A=0x00FF, B=0x0001, c_in=0 -> after 4 cycles out_valid=1, sum=0x0100, c_out=0.
//  2. A=0xFFFF, B=0x0001 -> sum=0x0000, c_out=1. A=0x1234, B=0x4321, c_in=1 -> sum=0x5556, c_out=0.
//  3. Backpressure: hold out_ready=0 for 3 cycles in DONE -> sum/c_out/out_valid stable; accept on cycle 4; in_ready=1 next cycle.
//  4. Drive in_valid=1 with new operands during RUN -> not captured; the running result is unchanged; new op accepted only in IDLE.
//  5. Assert rst after 2 RUN cycles -> out_valid never pulses; all outputs 0; the next op after release is correct.
//  6. NIBBLE_ADD_SUB_EN: A=0x0005, B=0x0007, op_sub=1 -> sum=0xFFFE, c_out=0. A=0x0007, B=0x0005 -> sum=0x0002, c_out=1.

Source files
------------

// File: rtl/nibble_add_pkg.sv
// ----------------------------------------------------------------------------
// nibble_add_pkg
// Shared definitions for the nibble-serial adder:
//   NIBBLE_W   - width of the shared ripple-carry slice (4 bits)
//   state_t    - sequencer FSM states {IDLE, RUN, DONE}
//   cnt_width  - width of a counter that indexes 'nibbles' nibbles
// ----------------------------------------------------------------------------
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-nibble operand still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_adder.sv
// ----------------------------------------------------------------------------
// nibble_adder
// Combinational NIBBLE_W-bit ripple-carry slice built from 1-bit full-adder
// cells, one cell per loop iteration.
// Ports:
//   a, b  in   NIBBLE_W  addend nibbles
//   ci    in   1         carry into bit 0
//   s     out  NIBBLE_W  sum nibble
//   co    out  1         carry out of the top bit
// ----------------------------------------------------------------------------
module nibble_adder
    import nibble_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic carry;

    // NOTE: blocking assignments are correct here; 'carry' is a combinational
    // ripple variable updated in program order, not a stored state.
    always_comb begin
        carry = ci;
        s     = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/nibble_add_seq.sv
// ----------------------------------------------------------------------------
// nibble_add_seq
// Multi-cycle WIDTH-bit adder that pushes one nibble per clock (LSB first)
// through a single shared nibble_adder slice, with the carry registered
// between nibbles. Operands arrive and results leave over valid/ready.
//
// Optional feature macro: NIBBLE_ADD_SUB_EN
//   When defined, an op_sub input selects A-B (B inverted, carry-in forced 1).
//   When undefined, op_sub does not exist and the block only adds.
//
// Parameters:
//   WIDTH      operand/result width; multiple of 4 and >= 4
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      sequencer idle and able to accept operands
//   op_a       in   WIDTH  operand A
//   op_b       in   WIDTH  operand B
//   c_in       in   1      carry into nibble 0
//   op_sub     in   1      1 = A-B (only with NIBBLE_ADD_SUB_EN)
//   out_valid  out  1      result valid (DONE state)
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result
//   c_out      out  1      carry out of the top nibble
//   busy       out  1      high in RUN or DONE
// ----------------------------------------------------------------------------
module nibble_add_seq
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             c_in,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
        $error("nibble_add_seq: WIDTH must be a multiple of 4 and >= 4");
    end

    // Operands and result are held as nibble arrays so the counter indexes
    // them directly.
    typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] nib_vec_t;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             carry_q,   carry_d;
    nib_vec_t         a_q,       a_d;
    nib_vec_t         b_q,       b_d;
    nib_vec_t         sum_q,     sum_d;
    logic             c_out_q,   c_out_d;
    logic             sub_q,     sub_d;

    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_co;
    logic                accept;

    nibble_adder u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // Held low during reset so a producer never sees a handshake it could
    // mistake for an accept while the state registers are cleared.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;

    always_comb begin
        // NOTE: every _d takes its _q value first so each branch below only
        // writes what changes and no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        sub_d   = sub_q;

        // Subtraction is A + ~B + 1: invert B per nibble, carry register
        // was preloaded with 1 at accept.
        slice_a = a_q[cnt_q];
        slice_b = sub_q ? ~b_q[cnt_q] : b_q[cnt_q];

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    sub_d   = 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
                    sub_d   = op_sub;
                    if (op_sub) begin
                        carry_d = 1'b1;
                    end
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[cnt_q] = slice_s;
                carry_d      = slice_co;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    c_out_d = slice_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the datapath registers are reset along with the FSM so an
    // aborted run leaves sum/c_out at zero instead of a partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            sub_q   <= sub_d;
        end
    end

endmodule

// File: tb/tb_nibble_add_seq.sv
// ----------------------------------------------------------------------------
// tb_nibble_add_seq
// Directed self-checking bench for nibble_add_seq with WIDTH=16.
// Inputs change 1ns after a rising edge; outputs are sampled at that point.
// The subtract scenario is compiled in only with NIBBLE_ADD_SUB_EN.
// ----------------------------------------------------------------------------
module tb_nibble_add_seq;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             c_in;
`ifdef NIBBLE_ADD_SUB_EN
    logic             op_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nibble_add_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .c_in      (c_in),
`ifdef NIBBLE_ADD_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    // Stimulus helper: waits (bounded) for in_ready, presents operands for
    // one edge. ok reports whether in_ready was high at the accept edge.
    task automatic do_accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic ci, output bit ok);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        op_a     = a;
        op_b     = b;
        c_in     = ci;
        in_valid = 1'b1;
        ok       = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges until out_valid, capped at 20 so a dead DUT still ends.
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (sum !== 16'h0000) begin bad++; $display("FAIL rst_sum got=%h exp=0000", sum); end
        total++; if (c_out !== 1'b0) begin bad++; $display("FAIL rst_c_out got=%b exp=0", c_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rel_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [WIDTH-1:0] va [4] = '{16'h00FF, 16'hFFFF, 16'h1234, 16'hFFFF};
        logic [WIDTH-1:0] vb [4] = '{16'h0001, 16'h0001, 16'h4321, 16'hFFFF};
        logic             vc [4] = '{1'b0,     1'b0,     1'b1,     1'b1};
        logic [WIDTH-1:0] es [4] = '{16'h0100, 16'h0000, 16'h5556, 16'hFFFF};
        logic             ec [4] = '{1'b0,     1'b1,     1'b0,     1'b1};
        for (int i = 0; i < 4; i++) begin
            bit ok;
            int lat;
            do_accept(va[i], vb[i], vc[i], ok);
            total++; if (!ok) begin bad++; $display("FAIL add%0d_accept in_ready low at accept", i); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL add%0d_busy got=%b exp=1", i, busy); end
            wait_done(lat);
            total++; if (lat != 4) begin bad++; $display("FAIL add%0d_latency got=%0d exp=4", i, lat); end
            total++; if (sum !== es[i]) begin bad++; $display("FAIL add%0d_sum got=%h exp=%h", i, sum, es[i]); end
            total++; if (c_out !== ec[i]) begin bad++; $display("FAIL add%0d_c_out got=%b exp=%b", i, c_out, ec[i]); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL add%0d_in_ready_done got=%b exp=0", i, in_ready); end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add%0d_out_valid_fall got=%b exp=0", i, out_valid); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL add%0d_in_ready_idle got=%b exp=1", i, in_ready); end
            total++; if (sum !== es[i]) begin bad++; $display("FAIL add%0d_sum_held got=%h exp=%h", i, sum, es[i]); end
            total++; if (c_out !== ec[i]) begin bad++; $display("FAIL add%0d_c_out_held got=%b exp=%b", i, c_out, ec[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        do_accept(16'hABCD, 16'h1111, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_accept in_ready low at accept"); end
        wait_done(lat);
        total++; if (lat != 4) begin bad++; $display("FAIL bp_latency got=%0d exp=4", lat); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d_out_valid got=%b exp=1", k, out_valid); end
            total++; if (sum !== 16'hBCDE) begin bad++; $display("FAIL bp_hold%0d_sum got=%h exp=bcde", k, sum); end
            total++; if (c_out !== 1'b0) begin bad++; $display("FAIL bp_hold%0d_c_out got=%b exp=0", k, c_out); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold%0d_in_ready got=%b exp=0", k, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_no_overlap();
        bit ok;
        int lat;
        do_accept(16'h0F0F, 16'h0101, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL ovl_accept in_ready low at accept"); end
        // Intruding request held through RUN and DONE.
        op_a     = 16'hFFFF;
        op_b     = 16'hFFFF;
        c_in     = 1'b1;
        in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ovl_run%0d_in_ready got=%b exp=0", k, in_ready); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovl_run%0d_out_valid got=%b exp=0", k, out_valid); end
        end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovl_done_out_valid got=%b exp=1", out_valid); end
        total++; if (sum !== 16'h1010) begin bad++; $display("FAIL ovl_sum got=%h exp=1010", sum); end
        total++; if (c_out !== 1'b0) begin bad++; $display("FAIL ovl_c_out got=%b exp=0", c_out); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ovl_done_in_ready got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ovl_idle_in_ready got=%b exp=1", in_ready); end
        total++; if (sum !== 16'h1010) begin bad++; $display("FAIL ovl_idle_sum got=%h exp=1010", sum); end
        // Pending request is now taken in IDLE.
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ovl_second_busy got=%b exp=1", busy); end
        wait_done(lat);
        total++; if (lat != 4) begin bad++; $display("FAIL ovl_second_latency got=%0d exp=4", lat); end
        total++; if (sum !== 16'hFFFF) begin bad++; $display("FAIL ovl_second_sum got=%h exp=ffff", sum); end
        total++; if (c_out !== 1'b1) begin bad++; $display("FAIL ovl_second_c_out got=%b exp=1", c_out); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        bit ok;
        int lat;
        do_accept(16'h1111, 16'h2222, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL abort_accept in_ready low at accept"); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
        total++; if (sum !== 16'h0000) begin bad++; $display("FAIL abort_sum got=%h exp=0000", sum); end
        total++; if (c_out !== 1'b0) begin bad++; $display("FAIL abort_c_out got=%b exp=0", c_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_in_ready got=%b exp=0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_hold%0d_out_valid got=%b exp=0", k, out_valid); end
        end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_rel_in_ready got=%b exp=1", in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_idle%0d_out_valid got=%b exp=0", k, out_valid); end
        end
        do_accept(16'h7FFF, 16'h0001, 1'b0, ok);
        total++; if (!ok) begin bad++; $display("FAIL abort_next_accept in_ready low at accept"); end
        wait_done(lat);
        total++; if (lat != 4) begin bad++; $display("FAIL abort_next_latency got=%0d exp=4", lat); end
        total++; if (sum !== 16'h8000) begin bad++; $display("FAIL abort_next_sum got=%h exp=8000", sum); end
        total++; if (c_out !== 1'b0) begin bad++; $display("FAIL abort_next_c_out got=%b exp=0", c_out); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

`ifdef NIBBLE_ADD_SUB_EN
    task automatic test_sub();
        logic [WIDTH-1:0] va [2] = '{16'h0005, 16'h0007};
        logic [WIDTH-1:0] vb [2] = '{16'h0007, 16'h0005};
        logic [WIDTH-1:0] es [2] = '{16'hFFFE, 16'h0002};
        logic             ec [2] = '{1'b0,     1'b1};
        for (int i = 0; i < 2; i++) begin
            bit ok;
            int lat;
            op_sub = 1'b1;
            // c_in deliberately 0: subtraction must ignore it.
            do_accept(va[i], vb[i], 1'b0, ok);
            op_sub = 1'b0;
            total++; if (!ok) begin bad++; $display("FAIL sub%0d_accept in_ready low at accept", i); end
            wait_done(lat);
            total++; if (lat != 4) begin bad++; $display("FAIL sub%0d_latency got=%0d exp=4", i, lat); end
            total++; if (sum !== es[i]) begin bad++; $display("FAIL sub%0d_sum got=%h exp=%h", i, sum, es[i]); end
            total++; if (c_out !== ec[i]) begin bad++; $display("FAIL sub%0d_c_out got=%b exp=%b", i, c_out, ec[i]); end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        c_in      = 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
        op_sub    = 1'b0;
`endif
        test_reset();
        test_add();
        test_backpressure();
        test_no_overlap();
        test_reset_abort();
`ifdef NIBBLE_ADD_SUB_EN
        test_sub();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
